// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared bus header with state encoding, slave indexing and level constants
package bus_ctrl_pkg;
    localparam int               ST_W        = 2;
    localparam logic [ST_W-1:0]  ST_IDLE     = 2'd0;
    localparam logic [ST_W-1:0]  ST_ACCESS   = 2'd1;
    localparam logic [ST_W-1:0]  ST_DONE     = 2'd2;
    localparam logic [ST_W-1:0]  ST_ERR      = 2'd3;
    localparam int               IDX_W       = 3;
    localparam int               SLV_CNT     = 8;
    localparam logic [7:0]       DEF_TIMEOUT = 8'd16;
    localparam logic             EN          = 1'b1;
    localparam logic             DIS         = 1'b0;
endpackage

// File: rtl/bus_ctrl_addr_dec.sv
// bus_addr_dec: slave index to one-hot chip-select decode
module bus_addr_dec
    import bus_ctrl_pkg::*;
#(
    parameter int N = SLV_CNT
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     cs
);
    // one-hot select of the addressed slave
    always_comb cs = {{(N-1){1'b0}}, 1'b1} << idx;
endmodule

// File: rtl/bus_ctrl.sv
// bus_ctrl: single-master to multi-slave access controller with ready timeout
module bus_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = DEF_TIMEOUT,
    parameter int         SLV_NUM = SLV_CNT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_req,
    input  logic [29:0]           m_addr,
    input  logic                  m_rw,
    input  logic [31:0]           m_wr_data,
    output logic [31:0]           m_rd_data,
    output logic                  m_rdy,
    output logic                  m_err,
    output logic                  bus_busy,
    output logic [SLV_NUM-1:0]    s_cs,
    output logic [29:0]           s_addr,
    output logic                  s_rw,
    output logic [31:0]           s_wr_data,
    input  logic [SLV_NUM*32-1:0] s_rd_data,
    input  logic [SLV_NUM-1:0]    s_rdy
);
    logic [ST_W-1:0]    state;
    logic [7:0]         cnt;
    logic [SLV_NUM-1:0] dec_cs;
    logic               rdy_hit;
    logic [31:0]        rd_sel;

    bus_addr_dec #(.N(SLV_NUM)) u_dec (
        .idx (m_addr[29:27]),
        .cs  (dec_cs)
    );

    // the latched address still carries the slave index, so ready/data are muxed from it
    always_comb begin
        rdy_hit = s_rdy[s_addr[29:27]];
        rd_sel  = s_rd_data[{s_addr[29:27], 5'd0} +: 32];
    end

    // access sequencing: capture, wait for selected ready or timeout, one-cycle completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            s_cs      <= '0;
            s_addr    <= '0;
            s_rw      <= DIS;
            s_wr_data <= '0;
            m_rd_data <= '0;
            m_rdy     <= DIS;
            m_err     <= DIS;
            bus_busy  <= DIS;
        end else begin
            case (state)
                ST_IDLE: begin
                    m_rdy     <= DIS;
                    m_err     <= DIS;
                    m_rd_data <= '0;
                    if (m_req) begin
                        s_addr    <= m_addr;
                        s_rw      <= m_rw;
                        s_wr_data <= m_wr_data;
                        s_cs      <= dec_cs;
                        bus_busy  <= EN;
                        cnt       <= 8'd0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 8'd1;
                    if (rdy_hit) begin
                        m_rd_data <= s_rw ? rd_sel : 32'd0;
                        m_rdy     <= EN;
                        m_err     <= DIS;
                        s_cs      <= '0;
                        state     <= ST_DONE;
                    end else if (cnt == TIMEOUT - 8'd1) begin
                        m_rd_data <= '0;
                        m_rdy     <= EN;
                        m_err     <= EN;
                        s_cs      <= '0;
                        state     <= ST_ERR;
                    end
                end
                default: begin
                    m_rdy     <= DIS;
                    m_err     <= DIS;
                    m_rd_data <= '0;
                    bus_busy  <= DIS;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: randomized and directed checks of bus_ctrl against a transaction-level model
module tb_bus_ctrl;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          m_req;
    logic [29:0]   m_addr;
    logic          m_rw;
    logic [31:0]   m_wr_data;
    logic [31:0]   m_rd_data;
    logic          m_rdy;
    logic          m_err;
    logic          bus_busy;
    logic [7:0]    s_cs;
    logic [29:0]   s_addr;
    logic          s_rw;
    logic [31:0]   s_wr_data;
    logic [255:0]  s_rd_data;
    logic [7:0]    s_rdy;

    int errors = 0;
    int checks = 0;

    bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_rw      (m_rw),
        .m_wr_data (m_wr_data),
        .m_rd_data (m_rd_data),
        .m_rdy     (m_rdy),
        .m_err     (m_err),
        .bus_busy  (bus_busy),
        .s_cs      (s_cs),
        .s_addr    (s_addr),
        .s_rw      (s_rw),
        .s_wr_data (s_wr_data),
        .s_rd_data (s_rd_data),
        .s_rdy     (s_rdy)
    );

    always #5 clk = ~clk;

    task automatic randomize_slaves();
        for (int i = 0; i < 8; i++) s_rd_data[i*32 +: 32] = $urandom;
    endtask

    // One transaction, entered and left at a negedge with the DUT idle.
    // delay = ACCESS cycle (1-based) in which the target slave is ready; 0 = never.
    task automatic run_txn(input logic [29:0] addr, input logic rw, input logic [31:0] wd,
                           input int delay, input logic [7:0] noise, input logic [31:0] rd_val,
                           input logic hold, input logic drop_ok);
        logic [7:0]  oh;
        logic [7:0]  nz;
        int          n;
        logic        exp_err;
        logic [31:0] exp_rd;
        oh      = 8'd1 << addr[29:27];
        nz      = noise & ~oh;
        exp_err = (delay == 0) || (delay > TO);
        n       = exp_err ? TO : delay;
        exp_rd  = (exp_err || !rw) ? 32'd0 : rd_val;
        m_req = 1'b1; m_addr = addr; m_rw = rw; m_wr_data = wd; s_rdy = nz;
        randomize_slaves();
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            checks++;
            if (s_cs !== oh) begin errors++; $display("FAIL access_cs k=%0d got=%h exp=%h", k, s_cs, oh); end
            checks++;
            if (s_addr !== addr || s_rw !== rw || s_wr_data !== wd) begin
                errors++; $display("FAIL access_fwd k=%0d got=%h/%b/%h exp=%h/%b/%h", k, s_addr, s_rw, s_wr_data, addr, rw, wd);
            end
            checks++;
            if (bus_busy !== 1'b1 || m_rdy !== 1'b0) begin
                errors++; $display("FAIL access_flags k=%0d busy=%b rdy=%b exp busy=1 rdy=0", k, bus_busy, m_rdy);
            end
            if (drop_ok) m_req = 1'($urandom_range(0, 1));
            m_addr = $urandom; m_wr_data = $urandom; m_rw = 1'($urandom_range(0, 1));
            randomize_slaves();
            s_rdy = nz | ((k == delay) ? oh : 8'h00);
            if (k == delay) s_rd_data[addr[29:27]*32 +: 32] = rd_val;
        end
        @(negedge clk);
        checks++;
        if (m_rdy !== 1'b1 || m_err !== exp_err) begin
            errors++; $display("FAIL done_pulse got rdy=%b err=%b exp rdy=1 err=%b", m_rdy, m_err, exp_err);
        end
        checks++;
        if (m_rd_data !== exp_rd) begin errors++; $display("FAIL done_data got=%h exp=%h", m_rd_data, exp_rd); end
        checks++;
        if (s_cs !== 8'h00 || bus_busy !== 1'b1) begin
            errors++; $display("FAIL done_cs got cs=%h busy=%b exp cs=00 busy=1", s_cs, bus_busy);
        end
        s_rdy = 8'h00;
        m_req = hold;
        @(negedge clk);
        checks++;
        if (m_rdy !== 1'b0 || bus_busy !== 1'b0 || s_cs !== 8'h00) begin
            errors++; $display("FAIL idle_after got rdy=%b busy=%b cs=%h exp 0/0/00", m_rdy, bus_busy, s_cs);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; m_req = 1'b1; m_addr = 30'h1000_0000; m_rw = 1'b1; m_wr_data = '1; s_rdy = 8'hFF;
        randomize_slaves();
        repeat (3) @(negedge clk);
        checks++;
        if (s_cs !== 8'h00 || m_rdy !== 1'b0 || m_err !== 1'b0 || bus_busy !== 1'b0 || m_rd_data !== 32'd0) begin
            errors++; $display("FAIL reset_state got cs=%h rdy=%b err=%b busy=%b rd=%h exp all 0", s_cs, m_rdy, m_err, bus_busy, m_rd_data);
        end
        m_req = 1'b0; s_rdy = 8'h00;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_busy !== 1'b0 || s_cs !== 8'h00) begin
            errors++; $display("FAIL idle_no_req got busy=%b cs=%h exp 0/00", bus_busy, s_cs);
        end
    endtask

    task automatic test_read_slave2();
        run_txn(30'h1000_0004, 1'b1, 32'h0, 1, 8'h00, 32'hDEADBEEF, 1'b0, 1'b0);
    endtask

    task automatic test_write_slave7();
        run_txn(30'h3800_0000, 1'b0, 32'h12345678, 5, 8'h00, 32'hCAFEF00D, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(30'h0000_0010, 1'b1, 32'h0, 0, 8'h00, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_wrong_slave();
        run_txn(30'h0800_0000, 1'b1, 32'h0, 0, 8'h01, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_boundary();
        run_txn(30'h2000_0abc, 1'b1, 32'h0, TO, 8'h00, 32'h5A5A_1234, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn(30'h1800_0001, 1'b1, 32'h0, 2, 8'h00, 32'h1111_2222, 1'b1, 1'b0);
        run_txn(30'h2800_0002, 1'b0, 32'hABCD_EF01, 3, 8'h00, 32'h0, 1'b1, 1'b0);
        run_txn(30'h3000_0003, 1'b1, 32'h0, 1, 8'h00, 32'h3333_4444, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_access();
        m_req = 1'b1; m_addr = 30'h1800_0040; m_rw = 1'b1; m_wr_data = 32'h0; s_rdy = 8'h00;
        @(posedge clk);
        repeat (2) @(negedge clk);
        m_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (s_cs !== 8'h00 || m_rdy !== 1'b0 || m_err !== 1'b0 || bus_busy !== 1'b0 || m_rd_data !== 32'd0) begin
            errors++; $display("FAIL reset_async got cs=%h rdy=%b err=%b busy=%b rd=%h exp all 0", s_cs, m_rdy, m_err, bus_busy, m_rd_data);
        end
        s_rdy = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (m_rdy !== 1'b0) begin errors++; $display("FAIL reset_no_rdy k=%0d got=%b exp=0", k, m_rdy); end
        end
        reset = 1'b0; s_rdy = 8'h00;
        @(negedge clk);
        checks++;
        if (m_rdy !== 1'b0 || bus_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got rdy=%b busy=%b exp 0/0", m_rdy, bus_busy);
        end
        run_txn(30'h1800_0040, 1'b1, 32'h0, 1, 8'h00, 32'h600D_F00D, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int d;
            d = (($urandom_range(0, 7)) == 0) ? 0 : int'($urandom_range(1, TO + 3));
            run_txn(30'($urandom), 1'($urandom_range(0, 1)), $urandom, d, 8'($urandom),
                    $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1; m_req = 1'b0; m_addr = '0; m_rw = 1'b0; m_wr_data = '0;
        s_rd_data = '0; s_rdy = '0;
        @(negedge clk);
        test_reset();
        test_read_slave2();
        test_write_slave7();
        test_timeout();
        test_wrong_slave();
        test_boundary();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd16, meaning the number of ACCESS cycles without s_rdy before the access is aborted.
REQ-002 SHALL have parameter SLV_NUM, default 8, meaning the number of decoded slaves (fixed; the index is addr[29:27]).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous and active-high; reset polarity and synchronicity are fixed by this requirement.
REQ-005 SHALL have port m_req, input, 1, the granted master's access request (level, held until m_rdy).
REQ-006 SHALL have port m_addr, input, 30, word address.
REQ-007 SHALL have port m_rw, input, 1, with 1 = read and 0 = write.
REQ-008 SHALL have port m_wr_data, input, 32, write data.
REQ-009 SHALL have port m_rd_data, output, 32, read data, valid only while m_rdy=1.
REQ-010 SHALL have port m_rdy, output, 1, a one-cycle completion pulse to the master.
REQ-011 SHALL have port m_err, output, 1, a timeout flag, qualified by m_rdy.
REQ-012 SHALL have port bus_busy, output, 1, high from request capture through m_rdy; it tells the arbiter to hold the current grant.
REQ-013 SHALL have port s_cs, output, 8, one-hot slave select.
REQ-014 SHALL have ports s_addr (30), s_rw (1) and s_wr_data (32), all outputs: the latched request forwarded to the slaves.
REQ-015 SHALL have port s_rd_data, input, 8x32 (flattened 256), per-slave read data.
REQ-016 SHALL have port s_rdy, input, 8, per-slave ready.

Function
REQ-017 SHALL implement a 4-state FSM: IDLE, ACCESS, DONE, ERR.
REQ-018 IDLE: if m_req=1, SHALL latch m_addr, m_rw and m_wr_data, decode idx=addr[29:27], set s_cs to one-hot(idx), set bus_busy=1, and go to ACCESS. Otherwise it SHALL stay in IDLE with s_cs=0.
REQ-019 ACCESS: s_cs, s_addr, s_rw and s_wr_data SHALL be held stable. The 8-bit wait counter SHALL increment each cycle.
REQ-020 ACCESS: if s_rdy[idx]=1, the controller SHALL capture s_rd_data[idx] (or 0 on a write), clear s_cs, and go to DONE. s_rdy bits of unselected slaves SHALL be ignored.
REQ-021 ACCESS: if the counter reaches TIMEOUT-1 and s_rdy[idx]=0, the controller SHALL clear s_cs and go to ERR. If s_rdy[idx]=1 in that same cycle, ready SHALL win and the FSM goes to DONE.
REQ-022 DONE: SHALL drive m_rdy=1, m_err=0 and m_rd_data=captured value for exactly one cycle, then go to IDLE with bus_busy=0.
REQ-023 ERR: SHALL drive m_rdy=1, m_err=1 and m_rd_data=0 for exactly one cycle, then go to IDLE.
REQ-024 Minimum latency SHALL be 2 cycles: request captured at edge N; s_rdy sampled at edge N+1 moves the FSM to DONE; m_rdy is high during cycle N+2.
REQ-025 m_req held high after m_rdy SHALL start a new access from IDLE on the next cycle. No back-to-back access SHALL be possible without passing through IDLE.
REQ-026 m_req deasserted mid-access SHALL be ignored; the access runs to DONE or ERR.
REQ-027 The wait counter SHALL clear on entry to ACCESS and SHALL NOT wrap, since TIMEOUT bounds it.
REQ-028 All outputs SHALL be registered; m_rdy, m_err and bus_busy SHALL be glitch-free.

Reset
REQ-029 While reset=1, the FSM SHALL be in IDLE and all outputs SHALL be 0: s_cs=8'h00, m_rdy=0, m_err=0, bus_busy=0, m_rd_data=0. Latches and the counter SHALL also be 0.
REQ-030 Reset asserted mid-access SHALL abort it immediately; no m_rdy pulse SHALL be produced.

Structure
REQ-031 The shared bus header SHALL hold the state encoding and width, the slave-index width (3), slave count (8), default timeout, and the enable/disable level macros.
REQ-032 The address decode (addr[29:27] to one-hot 8) SHALL be a separate sub-module named bus_addr_dec.

Verification
REQ-033 Read slave 2: m_addr=30'h1000_0004, m_rw=1, s_rdy[2]=1 one cycle after capture, s_rd_data[2]=32'hDEADBEEF -> s_cs=8'h04 for one cycle; m_rdy pulses at cycle N+2 with m_rd_data=32'hDEADBEEF and m_err=0.
REQ-034 Write slave 7: m_addr=30'h3800_0000, m_rw=0, m_wr_data=32'h12345678, s_rdy[7] after 5 cycles -> s_cs=8'h80 held for 5 cycles, s_wr_data=32'h12345678 stable throughout, m_rdy then pulses with m_err=0.
REQ-035 Timeout: target slave 0 and never assert s_rdy -> after 16 ACCESS cycles, m_rdy=1, m_err=1, m_rd_data=0, s_cs=0; bus_busy falls the following cycle.
REQ-036 Wrong-slave ready: target slave 1 while s_rdy=8'h01 is asserted -> the access is not completed and ends in ERR after the timeout.
REQ-037 Reset mid-access: assert reset during cycle 3 of ACCESS -> all outputs go to 0 asynchronously and no m_rdy pulse appears; after reset is released, a new read completes normally.
REQ-038 Ready at the timeout boundary: s_rdy[idx]=1 in the same cycle the counter reaches 15 -> the FSM goes to DONE and m_err=0.
